// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface between the decode stage (master) and the RAW interlock (slave).
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [2:0]       id_rs;
    logic             id_rs_en;
    logic [2:0]       id_rt;
    logic             id_rt_en;
    logic [2:0]       id_rd;
    logic             id_wr_en;
    logic             mem_stall;
    logic             flush;
    logic             stall_id;
    logic             bubble_ex;
    logic             busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wr_en, mem_stall, flush,
        input  stall_id, bubble_ex, busy, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wr_en, mem_stall, flush,
        output stall_id, bubble_ex, busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Read-after-write interlock for the 5-stage pipeline: tracks in-flight destination registers
// in EX/MEM/WB and stalls ID until the writer retires.
module hazard_scoreboard #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave sb
);
    logic             ex_v, mem_v, wb_v;
    logic [2:0]       ex_rd, mem_rd, wb_rd;
    logic [CNT_W-1:0] count;
    logic             rs_match, rt_match, hazard;

    // With WB bypass the register file writes first, so the WB slot never blocks a read.
    always_comb begin
        rs_match = (ex_v && ex_rd == sb.id_rs) || (mem_v && mem_rd == sb.id_rs) ||
                   (!WB_BYPASS && wb_v && wb_rd == sb.id_rs);
        rt_match = (ex_v && ex_rd == sb.id_rt) || (mem_v && mem_rd == sb.id_rt) ||
                   (!WB_BYPASS && wb_v && wb_rd == sb.id_rt);
        hazard   = sb.id_valid && ((sb.id_rs_en && rs_match) || (sb.id_rt_en && rt_match));
    end

    assign sb.stall_id    = (hazard && !sb.flush) || sb.mem_stall;
    assign sb.bubble_ex   = hazard && !sb.mem_stall && !sb.flush;
    assign sb.busy        = ex_v || mem_v || wb_v;
    assign sb.stall_count = count;

    // A stalled or flushed ID instruction enters EX as an invalid slot, so older writers drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v   <= 1'b0;
            mem_v  <= 1'b0;
            wb_v   <= 1'b0;
            ex_rd  <= 3'd0;
            mem_rd <= 3'd0;
            wb_rd  <= 3'd0;
            count  <= '0;
        end else if (!sb.mem_stall) begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= !sb.flush && sb.id_valid && sb.id_wr_en && !hazard;
            ex_rd  <= sb.id_rd;
            if (hazard && !sb.flush && count != {CNT_W{1'b1}})
                count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against an instruction-history model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hazard_scoreboard_if #(.CNT_W(16)) bus_a ();
    hazard_scoreboard_if #(.CNT_W(2))  bus_s ();
    hazard_scoreboard_if #(.CNT_W(16)) bus_n ();

    hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .sb(bus_a.slave));
    hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .sb(bus_s.slave));
    hazard_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(16)) dut_nb  (.clk(clk), .rst(rst), .sb(bus_n.slave));

    always #5 clk = ~clk;

    typedef struct {
        bit       wr;
        logic [2:0] rd;
    } entry_t;

    // Newest instruction first; each entry is whatever entered EX on a non-frozen cycle.
    entry_t hist_a[$];
    entry_t hist_n[$];
    int     cnt_a, cnt_s, cnt_n;

    bit         cur_valid, cur_rs_en, cur_rt_en, cur_wr, cur_ms, cur_fl, cur_rst;
    logic [2:0] cur_rs, cur_rt, cur_rd;

    function automatic bit writer_pending(input bit use_n, input logic [2:0] r);
        int depth = use_n ? 3 : 2;
        for (int i = 0; i < depth; i++) begin
            if (use_n) begin
                if (i < hist_n.size() && hist_n[i].wr && hist_n[i].rd == r) return 1'b1;
            end else begin
                if (i < hist_a.size() && hist_a[i].wr && hist_a[i].rd == r) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit model_hazard(input bit use_n);
        return cur_valid && ((cur_rs_en && writer_pending(use_n, cur_rs)) ||
                             (cur_rt_en && writer_pending(use_n, cur_rt)));
    endfunction

    function automatic bit model_busy(input bit use_n);
        for (int i = 0; i < 3; i++) begin
            if (use_n) begin
                if (i < hist_n.size() && hist_n[i].wr) return 1'b1;
            end else begin
                if (i < hist_a.size() && hist_a[i].wr) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic apply_stimulus(input bit v, input logic [2:0] rs, input bit rs_en,
                                  input logic [2:0] rt, input bit rt_en, input logic [2:0] rd,
                                  input bit wr, input bit ms, input bit fl, input bit r);
        cur_valid = v;  cur_rs = rs; cur_rs_en = rs_en; cur_rt = rt; cur_rt_en = rt_en;
        cur_rd = rd;    cur_wr = wr; cur_ms = ms;       cur_fl = fl; cur_rst = r;
        rst = r;
        bus_a.id_valid = v; bus_a.id_rs = rs; bus_a.id_rs_en = rs_en; bus_a.id_rt = rt;
        bus_a.id_rt_en = rt_en; bus_a.id_rd = rd; bus_a.id_wr_en = wr; bus_a.mem_stall = ms; bus_a.flush = fl;
        bus_s.id_valid = v; bus_s.id_rs = rs; bus_s.id_rs_en = rs_en; bus_s.id_rt = rt;
        bus_s.id_rt_en = rt_en; bus_s.id_rd = rd; bus_s.id_wr_en = wr; bus_s.mem_stall = ms; bus_s.flush = fl;
        bus_n.id_valid = v; bus_n.id_rs = rs; bus_n.id_rs_en = rs_en; bus_n.id_rt = rt;
        bus_n.id_rt_en = rt_en; bus_n.id_rd = rd; bus_n.id_wr_en = wr; bus_n.mem_stall = ms; bus_n.flush = fl;
        @(negedge clk);
    endtask

    task automatic advance();
        bit     ha, hn;
        entry_t e;
        @(posedge clk);
        ha = model_hazard(1'b0);
        hn = model_hazard(1'b1);
        if (cur_rst) begin
            hist_a.delete();
            hist_n.delete();
            cnt_a = 0; cnt_s = 0; cnt_n = 0;
        end else if (!cur_ms) begin
            if (ha && !cur_fl) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_s < 3) cnt_s++;
            end
            if (hn && !cur_fl && cnt_n < 65535) cnt_n++;
            e.rd = cur_rd;
            e.wr = !cur_fl && cur_valid && cur_wr && !ha;
            hist_a.push_front(e);
            e.wr = !cur_fl && cur_valid && cur_wr && !hn;
            hist_n.push_front(e);
            if (hist_a.size() > 3) void'(hist_a.pop_back());
            if (hist_n.size() > 3) void'(hist_n.pop_back());
        end
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        advance();
    endtask

    task automatic test_reset();
        do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.bubble_ex, bus_a.busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b want=000", {bus_a.stall_id, bus_a.bubble_ex, bus_a.busy});
        end
        checks++;
        if (bus_a.stall_count !== 16'd0 || bus_s.stall_count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_count got=%0d/%0d want=0", bus_a.stall_count, bus_s.stall_count);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [3:0] want_a, want_n;
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        advance();
        want_a = 4'b0011;
        want_n = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({bus_a.stall_id, bus_a.bubble_ex} !== {2{want_a[i]}}) begin
                failures++;
                $display("[TB] FAIL b2b_bypass cyc=%0d got=%b%b want=%b", i, bus_a.stall_id, bus_a.bubble_ex, {2{want_a[i]}});
            end
            checks++;
            if ({bus_n.stall_id, bus_n.bubble_ex} !== {2{want_n[i]}}) begin
                failures++;
                $display("[TB] FAIL b2b_nobypass cyc=%0d got=%b%b want=%b", i, bus_n.stall_id, bus_n.bubble_ex, {2{want_n[i]}});
            end
            if (i == 3) begin
                checks++;
                if (bus_a.stall_count !== 16'd2 || bus_n.stall_count !== 16'd3) begin
                    failures++;
                    $display("[TB] FAIL b2b_count got=%0d/%0d want=2/3", bus_a.stall_count, bus_n.stall_count);
                end
            end
            advance();
        end
        // One independent instruction between writer and reader.
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        advance();
        apply_stimulus(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        advance();
        want_a = 4'b0001;
        want_n = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({bus_a.stall_id, bus_n.stall_id} !== {want_a[i], want_n[i]}) begin
                failures++;
                $display("[TB] FAIL one_behind cyc=%0d got=%b%b want=%b%b", i, bus_a.stall_id, bus_n.stall_id, want_a[i], want_n[i]);
            end
            advance();
        end
    endtask

    task automatic test_independent();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 4, 1, 5, 1, 0, 0, 0, 0, 0);
            checks++;
            if (bus_a.stall_id !== 1'b0 || bus_a.stall_count !== 16'd0) begin
                failures++;
                $display("[TB] FAIL independent cyc=%0d stall=%b count=%0d want=0/0", i, bus_a.stall_id, bus_a.stall_count);
            end
            advance();
        end
    endtask

    task automatic test_disabled_source();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        advance();
        apply_stimulus(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_a.stall_id !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rt_disabled got=%b want=0", bus_a.stall_id);
        end
        advance();
        do_reset();
        apply_stimulus(1, 1, 1, 0, 0, 2, 0, 0, 0, 0);
        advance();
        apply_stimulus(1, 2, 1, 2, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_n.stall_id} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL no_write_src got=%b%b want=00", bus_a.stall_id, bus_n.stall_id);
        end
        advance();
    endtask

    task automatic test_self_dependency();
        do_reset();
        apply_stimulus(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
        checks++;
        if (bus_a.stall_id !== 1'b0) begin
            failures++;
            $display("[TB] FAIL self_dep got=%b want=0", bus_a.stall_id);
        end
        advance();
        apply_stimulus(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
        checks++;
        if (bus_a.stall_id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL self_dep_next got=%b want=1", bus_a.stall_id);
        end
        advance();
    endtask

    task automatic test_mem_stall();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        advance();
        apply_stimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.bubble_ex, bus_a.busy} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL mstall_pre got=%b want=111", {bus_a.stall_id, bus_a.bubble_ex, bus_a.busy});
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
            checks++;
            if ({bus_a.stall_id, bus_a.bubble_ex} !== 2'b10 || bus_a.stall_count !== 16'd1) begin
                failures++;
                $display("[TB] FAIL mstall_hold cyc=%0d got=%b%b count=%0d want=10 count=1", i, bus_a.stall_id, bus_a.bubble_ex, bus_a.stall_count);
            end
            advance();
        end
        apply_stimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.bubble_ex} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL mstall_resume got=%b%b want=11", bus_a.stall_id, bus_a.bubble_ex);
        end
        advance();
        apply_stimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_a.stall_id !== 1'b0 || bus_a.stall_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL mstall_done stall=%b count=%0d want=0 count=2", bus_a.stall_id, bus_a.stall_count);
        end
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        advance();
        apply_stimulus(1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.bubble_ex, bus_a.busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL flush_cycle got=%b want=001", {bus_a.stall_id, bus_a.bubble_ex, bus_a.busy});
        end
        advance();
        apply_stimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.bubble_ex} !== 2'b11 || bus_a.stall_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL flush_mem_slot got=%b%b count=%0d want=11 count=0", bus_a.stall_id, bus_a.bubble_ex, bus_a.stall_count);
        end
        advance();
        apply_stimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_a.stall_id !== 1'b0 || bus_a.stall_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL flush_after stall=%b count=%0d want=0 count=1", bus_a.stall_id, bus_a.stall_count);
        end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        advance();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
            advance();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_s.stall_count !== 2'd3 || bus_a.stall_count !== 16'd5) begin
            failures++;
            $display("[TB] FAIL saturate got=%0d/%0d want=3/5", bus_s.stall_count, bus_a.stall_count);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        advance();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_s.stall_count !== 2'd0 || bus_s.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_reset count=%0d busy=%b want=0/0", bus_s.stall_count, bus_s.busy);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        advance();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        advance();
        apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus_a.stall_id, bus_a.busy} !== 2'b00 || bus_a.stall_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_stall got=%b%b count=%0d want=00 count=0", bus_a.stall_id, bus_a.busy, bus_a.stall_count);
        end
        advance();
    endtask

    task automatic test_random();
        bit ha, hn;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 9) < 8, 3'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                           3'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, 3'($urandom_range(0, 3)),
                           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                           $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0);
            ha = model_hazard(1'b0);
            hn = model_hazard(1'b1);
            checks++;
            if ({bus_a.stall_id, bus_a.bubble_ex, bus_a.busy} !==
                {(ha && !cur_fl) || cur_ms, ha && !cur_ms && !cur_fl, model_busy(1'b0)}) begin
                failures++;
                $display("[TB] FAIL rand_bypass cyc=%0d got=%b want=%b", i, {bus_a.stall_id, bus_a.bubble_ex, bus_a.busy},
                         {(ha && !cur_fl) || cur_ms, ha && !cur_ms && !cur_fl, model_busy(1'b0)});
            end
            checks++;
            if ({bus_n.stall_id, bus_n.bubble_ex, bus_n.busy} !==
                {(hn && !cur_fl) || cur_ms, hn && !cur_ms && !cur_fl, model_busy(1'b1)}) begin
                failures++;
                $display("[TB] FAIL rand_nobypass cyc=%0d got=%b want=%b", i, {bus_n.stall_id, bus_n.bubble_ex, bus_n.busy},
                         {(hn && !cur_fl) || cur_ms, hn && !cur_ms && !cur_fl, model_busy(1'b1)});
            end
            checks++;
            if (bus_a.stall_count !== 16'(cnt_a) || bus_s.stall_count !== 2'(cnt_s) || bus_n.stall_count !== 16'(cnt_n)) begin
                failures++;
                $display("[TB] FAIL rand_count cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, bus_a.stall_count,
                         bus_s.stall_count, bus_n.stall_count, cnt_a, cnt_s, cnt_n);
            end
            advance();
        end
    endtask

    initial begin
        cnt_a = 0; cnt_s = 0; cnt_n = 0;
        test_reset();
        test_back_to_back();
        test_independent();
        test_disabled_source();
        test_self_dependency();
        test_mem_stall();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
